// File: rtl/mem_arbiter_2m.sv
// Two-master arbiter and sequencer for a dual-port register-file memory.
// Sticky-owner arbitration with a burst cap, registered memory strobes, and
// a {valid, owner} pipeline that steers read data back to the issuing master.
module mem_arbiter_2m #(
  parameter  int DATA       = 16,
  parameter  int DEPTH      = 16,
  parameter  int BURST_MAX  = 4,
  parameter  int MEM_RD_LAT = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DATA-1:0] m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DATA-1:0] m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DATA-1:0] m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DATA-1:0] m1_rdata,
  output logic            mem_wr_en,
  output logic            mem_out_en,
  output logic [AW-1:0]   mem_wr_addr,
  output logic [AW-1:0]   mem_rd_addr,
  output logic [DATA-1:0] mem_wr_data,
  input  logic [DATA-1:0] mem_q_out
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BURST_MAX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            grant0, grant1;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DATA-1:0] sel_wdata;
  logic            wr_acc, rd_acc;

  logic            mem_wr_en_q, mem_out_en_q;
  logic [AW-1:0]   mem_wr_addr_q, mem_rd_addr_q;
  logic [DATA-1:0] mem_wr_data_q;
  // Bit k is the read issued k+1 cycles ago; bit MEM_RD_LAT lines up with q_out.
  logic [MEM_RD_LAT:0] rv_vld_q, rv_own_q;

  // Owner state and burst counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration: owner keeps the grant until it stops asking or its burst is spent while contested.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req) begin
          grant0  = 1'b1;
          state_d = OWN0;
          cnt_d   = CNT_ONE;
        end else if (m1_req) begin
          grant1  = 1'b1;
          state_d = OWN1;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      OWN0: begin
        if (m0_req && (!m1_req || (cnt_q < CNT_MAX))) begin
          grant0 = 1'b1;
          cnt_d  = (cnt_q < CNT_MAX) ? (cnt_q + CNT_ONE) : CNT_MAX;
        end else if (m1_req) begin
          grant1  = 1'b1;
          state_d = OWN1;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      OWN1: begin
        if (m1_req && (!m0_req || (cnt_q < CNT_MAX))) begin
          grant1 = 1'b1;
          cnt_d  = (cnt_q < CNT_MAX) ? (cnt_q + CNT_ONE) : CNT_MAX;
        end else if (m0_req) begin
          grant0  = 1'b1;
          state_d = OWN0;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Pick the accepted master's request fields and classify the access.
  always_comb begin
    if (grant1) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end else begin
      sel_we    = m0_we;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
    end
    wr_acc = (grant0 | grant1) & sel_we;
    rd_acc = (grant0 | grant1) & ~sel_we;
  end

  // Memory strobes one cycle after accept; address/data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wr_en_q   <= 1'b0;
      mem_out_en_q  <= 1'b0;
      mem_wr_addr_q <= {AW{1'b0}};
      mem_rd_addr_q <= {AW{1'b0}};
      mem_wr_data_q <= {DATA{1'b0}};
    end else begin
      mem_wr_en_q  <= wr_acc;
      mem_out_en_q <= rd_acc;
      if (wr_acc) begin
        mem_wr_addr_q <= sel_addr;
        mem_wr_data_q <= sel_wdata;
      end
      if (rd_acc) begin
        mem_rd_addr_q <= sel_addr;
      end
    end
  end

  // Track outstanding reads so data is routed to the issuer; reset drops them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv_vld_q <= {(MEM_RD_LAT+1){1'b0}};
      rv_own_q <= {(MEM_RD_LAT+1){1'b0}};
    end else begin
      rv_vld_q <= {rv_vld_q[MEM_RD_LAT-1:0], rd_acc};
      rv_own_q <= {rv_own_q[MEM_RD_LAT-1:0], grant1};
    end
  end

  // Grants are suppressed while reset is held so nothing looks accepted.
  assign m0_gnt      = grant0 & ~reset;
  assign m1_gnt      = grant1 & ~reset;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_out_en  = mem_out_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  // q_out is passed through during the rvalid cycle, zero otherwise.
  assign m0_rvalid   = rv_vld_q[MEM_RD_LAT] & ~rv_own_q[MEM_RD_LAT];
  assign m1_rvalid   = rv_vld_q[MEM_RD_LAT] &  rv_own_q[MEM_RD_LAT];
  assign m0_rdata    = m0_rvalid ? mem_q_out : {DATA{1'b0}};
  assign m1_rdata    = m1_rvalid ? mem_q_out : {DATA{1'b0}};

endmodule

// File: tb/tb_mem_arbiter_2m.sv
// Bench for mem_arbiter_2m: memory model, per-cycle reference checker,
// grant table, directed corner sequences and a randomized traffic phase.
module tb_mem_arbiter_2m;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int BM  = 4;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_wr_en, mem_out_en;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] mem_wr_data, mem_q_out;

  mem_arbiter_2m #(.DATA(DW), .DEPTH(16), .BURST_MAX(BM), .MEM_RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wr_en(mem_wr_en), .mem_out_en(mem_out_en), .mem_wr_addr(mem_wr_addr),
    .mem_rd_addr(mem_rd_addr), .mem_wr_data(mem_wr_data), .mem_q_out(mem_q_out)
  );

  always #5 clk = ~clk;

  // Register-file memory with a registered read port (one cycle latency).
  logic [DW-1:0] mem_arr [16];
  always @(posedge clk) begin
    if (mem_wr_en) mem_arr[mem_wr_addr] <= mem_wr_data;
    if (mem_out_en) mem_q_out <= mem_arr[mem_rd_addr];
  end

  typedef struct { int due; bit who; logic [DW-1:0] data; } rd_t;
  typedef struct { bit r0; bit r1; logic [1:0] eg; } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  // Reference: current owner (-1 none), consecutive grants, wait counters.
  int own = -1;
  int run = 0;
  int wait0 = 0;
  int wait1 = 0;
  rd_t rq [$];
  logic [DW-1:0] ref_mem [16];
  logic          e_we = 1'b0, e_re = 1'b0;
  logic [AW-1:0] e_wa = '0, e_ra = '0;
  logic [DW-1:0] e_wd = '0;
  vec_t tv [22];
  bit g0p, g1p;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endfunction

  // One cycle of the reference model, evaluated at the falling edge.
  task automatic monitor_cycle();
    int win;
    bit r0, r1, mine, theirs, w;
    bit [1:0] exp_rv, exp_g;
    rd_t e, n;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    cyc++;
    if (reset) begin
      chk("reset_outputs", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wr_en, mem_out_en,
                            mem_wr_addr, mem_rd_addr, mem_wr_data, m0_rdata, m1_rdata}, 64'd0);
      own = -1; run = 0; wait0 = 0; wait1 = 0;
      rq.delete();
      e_we = 1'b0; e_re = 1'b0; e_wa = '0; e_ra = '0; e_wd = '0;
    end else begin
      chk("mem_strobes", {mem_wr_en, mem_out_en, mem_wr_addr, mem_rd_addr, mem_wr_data},
                         {e_we, e_re, e_wa, e_ra, e_wd});
      exp_rv = 2'b00;
      e = '{due: 0, who: 1'b0, data: '0};
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e = rq.pop_front();
        exp_rv = e.who ? 2'b10 : 2'b01;
      end
      chk("rvalid", {m1_rvalid, m0_rvalid}, exp_rv);
      if (exp_rv[0]) chk("m0_rdata", m0_rdata, e.data);
      if (exp_rv[1]) chk("m1_rdata", m1_rdata, e.data);
      r0 = m0_req; r1 = m1_req;
      if (own < 0) begin
        win = r0 ? 0 : (r1 ? 1 : -1);
      end else begin
        mine   = (own == 0) ? r0 : r1;
        theirs = (own == 0) ? r1 : r0;
        if (mine && !(theirs && run == BM)) win = own;
        else if (theirs) win = 1 - own;
        else win = -1;
      end
      exp_g = (win == 0) ? 2'b01 : ((win == 1) ? 2'b10 : 2'b00);
      chk("gnt", {m1_gnt, m0_gnt}, exp_g);
      if (r0 && win != 0) wait0++; else wait0 = 0;
      if (r1 && win != 1) wait1++; else wait1 = 0;
      if (r0) chk("starve_m0", wait0 > BM, 1'b0);
      if (r1) chk("starve_m1", wait1 > BM, 1'b0);
      e_we = 1'b0; e_re = 1'b0;
      if (win >= 0) begin
        w = (win == 1) ? m1_we : m0_we;
        a = (win == 1) ? m1_addr : m0_addr;
        d = (win == 1) ? m1_wdata : m0_wdata;
        if (w) begin
          ref_mem[a] = d;
          e_we = 1'b1; e_wa = a; e_wd = d;
        end else begin
          e_re = 1'b1; e_ra = a;
          n.due = cyc + 1 + LAT; n.who = (win == 1); n.data = ref_mem[a];
          rq.push_back(n);
        end
      end
      if (win < 0) begin
        own = -1; run = 0;
      end else if (win == own) begin
        run = (run < BM) ? run + 1 : BM;
      end else begin
        own = win; run = 1;
      end
    end
  endtask

  // Wait (bounded) for a read return, checking latency, data and the other master.
  task automatic wait_rv(input bit who, input logic [DW-1:0] exp, input string nm);
    bit got;
    got = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (who ? m1_rvalid : m0_rvalid) begin
        got = 1'b1;
        chk({nm, "_lat"}, k, 2);
        chk({nm, "_data"}, who ? m1_rdata : m0_rdata, exp);
        chk({nm, "_other_rvalid"}, who ? m0_rvalid : m1_rvalid, 1'b0);
      end
    end
    if (!got) chk({nm, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic run_all();
    // Reset with both requests high: grants must stay low.
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;

    // Grant table: tie bursts, owner drop, idle returns.
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      m0_req = tv[i].r0; m0_we = 1'b1; m0_addr = 4'd0; m0_wdata = 16'h0101;
      m1_req = tv[i].r1; m1_we = 1'b1; m1_addr = 4'd1; m1_wdata = 16'h0202;
      @(negedge clk);
      chk($sformatf("table[%0d]", i), {m1_gnt, m0_gnt}, tv[i].eg);
    end

    // Single master: write then read back the same word.
    @(posedge clk); #1 m0_req = 1'b1; m0_we = 1'b1; m0_addr = 4'd5; m0_wdata = 16'hA5A5; m1_req = 1'b0;
    @(negedge clk); chk("sm_wr_gnt", {m1_gnt, m0_gnt}, 2'b01);
    @(posedge clk); #1 m0_we = 1'b0;
    @(negedge clk); chk("sm_rd_gnt", {m1_gnt, m0_gnt}, 2'b01);
    chk("sm_wr_strobe", {mem_wr_en, mem_wr_addr, mem_wr_data}, {1'b1, 4'd5, 16'hA5A5});
    @(posedge clk); #1 m0_req = 1'b0;
    wait_rv(1'b0, 16'hA5A5, "sm_rd");

    // Cross-master coherence.
    @(posedge clk); #1 m1_req = 1'b1; m1_we = 1'b1; m1_addr = 4'd15; m1_wdata = 16'h1234;
    @(negedge clk); chk("xm_wr_gnt", {m1_gnt, m0_gnt}, 2'b10);
    @(posedge clk); #1 m1_req = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd15;
    @(negedge clk); chk("xm_rd_gnt", {m1_gnt, m0_gnt}, 2'b01);
    @(posedge clk); #1 m0_req = 1'b0;
    wait_rv(1'b0, 16'h1234, "xm_rd");

    // Reset while a read is in flight.
    @(posedge clk); #1 m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd3;
    @(negedge clk); chk("rst_rd_gnt", {m1_gnt, m0_gnt}, 2'b01);
    @(posedge clk); #1 reset = 1'b1; m0_req = 1'b0;
    @(negedge clk); chk("rst_mid_out", {mem_out_en, m0_rvalid, m0_gnt}, 3'b000);
    @(posedge clk); #1 m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk); chk("rst_gnt_gate", {m1_gnt, m0_gnt}, 2'b00);
    @(posedge clk); #1 reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("rst_no_rvalid", m0_rvalid, 1'b0);
    end
    @(posedge clk); #1 m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
    @(negedge clk); chk("rst_tie", {m1_gnt, m0_gnt}, 2'b01);
    @(posedge clk); #1 m0_req = 1'b0; m1_req = 1'b0;

    // Preload every word so random reads have known contents.
    for (int a = 0; a < 16; a++) begin
      @(posedge clk); #1 m0_req = 1'b1; m0_we = 1'b1; m0_addr = AW'(a); m0_wdata = DW'($urandom);
      @(negedge clk);
    end
    @(posedge clk); #1 m0_req = 1'b0;
    @(negedge clk); g0p = 1'b0; g1p = 1'b0;

    // Random traffic; a request holds its fields until granted.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (!(m0_req && !g0p)) begin
        m0_req = ($urandom_range(0, 3) != 0); m0_we = 1'($urandom_range(0, 1));
        m0_addr = AW'($urandom_range(0, 15)); m0_wdata = DW'($urandom);
      end
      if (!(m1_req && !g1p)) begin
        m1_req = ($urandom_range(0, 3) != 0); m1_we = 1'($urandom_range(0, 1));
        m1_addr = AW'($urandom_range(0, 15)); m1_wdata = DW'($urandom);
      end
      @(negedge clk); g0p = m0_gnt; g1p = m1_gnt;
    end
    @(posedge clk); #1 m0_req = 1'b0; m1_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    tv = '{
      '{1'b1, 1'b1, 2'b01}, '{1'b1, 1'b1, 2'b01}, '{1'b1, 1'b1, 2'b01}, '{1'b1, 1'b1, 2'b01},
      '{1'b1, 1'b1, 2'b10}, '{1'b1, 1'b1, 2'b10}, '{1'b1, 1'b1, 2'b10}, '{1'b1, 1'b1, 2'b10},
      '{1'b1, 1'b1, 2'b01}, '{1'b1, 1'b1, 2'b01},
      '{1'b0, 1'b1, 2'b10}, '{1'b0, 1'b1, 2'b10},
      '{1'b1, 1'b0, 2'b01}, '{1'b1, 1'b0, 2'b01},
      '{1'b0, 1'b0, 2'b00},
      '{1'b0, 1'b1, 2'b10}, '{1'b1, 1'b1, 2'b10}, '{1'b1, 1'b1, 2'b10}, '{1'b1, 1'b1, 2'b10},
      '{1'b1, 1'b1, 2'b01},
      '{1'b0, 1'b1, 2'b10},
      '{1'b0, 1'b0, 2'b00}
    };
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = '0; m1_wdata = '0;
    g0p = 1'b0; g1p = 1'b0;
    #2 reset = 1'b1;
    fork
      run_all();
      forever monitor_cycle();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_2m.md
Name: mem_arbiter_2m

Overview:
- Two-requester arbiter and sequencer for the team's DATA x DEPTH dual-port register-file memory. The memory has a write strobe, a read/output enable, separate write and read addresses, and a registered q_out.
- Shares the memory between master 0 and master 1 with one access per cycle. Uses a sticky-owner policy with a burst cap.
- Registers the memory control strobes and routes read data back to the issuing master with a valid flag.
- Sits between the two bus-side clients and the memory instance.

Parameters:
DATA, 16, data width in bits
DEPTH, 16, memory words; AW = $clog2(DEPTH)
BURST_MAX, 4, max consecutive grants to the current owner while the other master is requesting (>=1)
MEM_RD_LAT, 1, cycles from mem_out_en to valid mem_q_out (>=1)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
m0_req  input  1  master 0 access request
m0_we  input  1  master 0: 1=write, 0=read
m0_addr  input  AW  master 0 address
m0_wdata  input  DATA  master 0 write data
m0_gnt  output  1  master 0 request accepted this cycle (combinational)
m0_rvalid  output  1  master 0 read data valid
m0_rdata  output  DATA  master 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_* for master 1
mem_wr_en  output  1  memory write strobe (registered)
mem_out_en  output  1  memory read enable (registered)
mem_wr_addr  output  AW  memory write address (registered)
mem_rd_addr  output  AW  memory read address (registered)
mem_wr_data  output  DATA  memory write data (registered)
mem_q_out  input  DATA  memory read data

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE, burst_cnt=0.
  - All gnt/rvalid/rdata and mem_* outputs are 0.
  - In-flight reads are discarded; no rvalid is issued for them after reset releases.
- Handshake:
  - A request holds its fields stable until gnt is high. req&gnt at a clock edge means accepted.
  - At most one gnt is high per cycle. gnt is never high without the matching req.
- FSM states: IDLE, OWN0, OWN1. burst_cnt counts consecutive grants to the owner and saturates at BURST_MAX.
  - IDLE: m0_req wins (also on a tie). Otherwise m1_req wins. Winner x -> OWNx, cnt=1. No request -> stay IDLE.
  - OWNx, mx_req=1, and either other not requesting or cnt<BURST_MAX: grant x, cnt=min(cnt+1,BURST_MAX).
  - OWNx, other requesting and (cnt==BURST_MAX or mx_req=0): grant other -> OWNy, cnt=1.
  - OWNx, no requests: no grant -> IDLE, cnt=0.
- Memory sequencing:
  - Accept in cycle N drives mem strobes in cycle N+1.
  - Write: mem_wr_en=1, mem_wr_addr/mem_wr_data = master fields.
  - Read: mem_out_en=1, mem_rd_addr = master addr.
  - With no accept, strobes are 0 and addr/data hold their last value.
- Read return:
  - A pipeline of depth MEM_RD_LAT tracks {valid, owner}.
  - A read accepted at N gives my_rvalid=1 for exactly one cycle at N+1+MEM_RD_LAT, with my_rdata=mem_q_out (registered into the output or passed through, so that it is valid while rvalid is high).
  - Reads complete in accept order. Each master gets at most one rvalid per cycle.
- Ordering: a write accepted at N followed by a read of the same address accepted at N+1 or later, from either master, returns the new data.
- A master may hold req continuously. It receives a grant every cycle while uncontested. Back-to-back reads give a one-per-cycle rvalid stream.

Test Plan:
- Reset mid-traffic: m0 read of addr 3 accepted at N, reset asserted at N+1 -> all outputs 0 immediately; no m0_rvalid after release; next tie is granted to m0.
- Single master: m0 writes 0xA5A5 @5, then reads @5 on the next cycle -> gnt each cycle; mem_wr_en at N+1; m0_rvalid at N+1+MEM_RD_LAT+1 with m0_rdata=0xA5A5; m1_gnt stays 0.
- Tie from IDLE: m0_req=m1_req=1 held for 10 cycles, BURST_MAX=4 -> grant pattern 0,0,0,0,1,1,1,1,0,0.
- Owner drops: OWN1 with cnt=2, m1_req->0 while m0_req=1 -> m0_gnt next cycle, state OWN0, cnt=1.
- Cross-master coherence: m1 writes 0x1234 @15, m0 reads @15 in the following cycle -> m0_rvalid with 0x1234; m1_rvalid never asserted.
- Random: 10000 ns with random req/we/addr/wdata against a reference memory model -> every accepted read returns model data to the correct master; never both gnt high; no starvation longer than BURST_MAX cycles.
